// File: rtl/dp_sequencer_pkg.sv
// Shared definitions for the datapath sequencer: instruction classes,
// ALU opcodes, instruction field positions and FSM state encoding.
package dp_sequencer_pkg;

    // Instruction class codes, carried in bits [31:30]
    localparam logic [1:0] CLS_LOAD = 2'b00;
    localparam logic [1:0] CLS_ALU  = 2'b01;
    localparam logic [1:0] CLS_CMP  = 2'b10;
    localparam logic [1:0] CLS_NOP  = 2'b11;

    // ALU opcodes, forwarded to the datapath unchanged
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_AND = 2'b11;

    // Instruction field positions (LSB of each field)
    localparam int F_CLS_LSB = 30;
    localparam int F_OP_LSB  = 28;
    localparam int F_RD_LSB  = 23;
    localparam int F_RS1_LSB = 18;
    localparam int F_RS2_LSB = 13;
    localparam int F_IMM_LSB = 0;
    localparam int IMM_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/dp_sequencer.sv
// Multi-cycle sequencer driving the register-file/ALU datapath: accepts one
// instruction at a time, steps IDLE -> READ -> WRITE -> RESP, and returns
// the captured result on a valid/ready response channel.
module dp_sequencer
    import dp_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [31:0]       Instr_in,
    input  logic              Instr_valid,
    output logic              Instr_ready,
    output logic              Rsp_valid,
    input  logic              Rsp_ready,
    output logic [DATA_W-1:0] Rsp_result,
    output logic              Rsp_zero,
    output logic [ADDR_W-1:0] Read_Addr_1,
    output logic [ADDR_W-1:0] Read_Addr_2,
    output logic [ADDR_W-1:0] Write_Addr,
    output logic              Write_Enable,
    output logic              Mux_cntrl,
    output logic [1:0]        opcode,
    output logic [DATA_W-1:0] Data_in,
    input  logic [DATA_W-1:0] result,
    input  logic              zero_flag
);

    state_e              state_q, state_d;
    logic [31:0]         instr_q, instr_d;
    logic                instr_ready_q, instr_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_zero_q, rsp_zero_d;
    logic [ADDR_W-1:0]   ra1_q, ra1_d;
    logic [ADDR_W-1:0]   ra2_q, ra2_d;
    logic [ADDR_W-1:0]   wa_q, wa_d;
    logic                we_q, we_d;
    logic                mux_q, mux_d;
    logic [1:0]          opcode_q, opcode_d;
    logic [DATA_W-1:0]   data_in_q, data_in_d;

    // Outputs are registered, so the values for the cycle after an accept
    // must come straight from Instr_in; afterwards from the latched copy.
    logic [31:0]         cur_instr;
    logic [1:0]          f_cls;
    logic [1:0]          f_op;
    logic [ADDR_W-1:0]   f_rd;
    logic [ADDR_W-1:0]   f_rs1;
    logic [ADDR_W-1:0]   f_rs2;
    logic [IMM_W-1:0]    f_imm;
    logic [DATA_W-1:0]   imm_sext;
    logic                accept;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    assign cur_instr = (state_q == ST_IDLE) ? Instr_in : instr_q;
    assign f_cls     = cur_instr[F_CLS_LSB +: 2];
    assign f_op      = cur_instr[F_OP_LSB  +: 2];
    assign f_rd      = cur_instr[F_RD_LSB  +: ADDR_W];
    assign f_rs1     = cur_instr[F_RS1_LSB +: ADDR_W];
    assign f_rs2     = cur_instr[F_RS2_LSB +: ADDR_W];
    assign f_imm     = cur_instr[F_IMM_LSB +: IMM_W];
    assign imm_sext  = sext_imm(f_imm);
    assign accept    = Instr_valid && instr_ready_q;

    // Next-state, response capture and next registered datapath controls
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    instr_d = Instr_in;
                    if (f_cls == CLS_NOP) begin
                        state_d      = ST_RESP;
                        rsp_result_d = '0;
                        rsp_zero_d   = 1'b1;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (f_cls == CLS_LOAD) begin
                    rsp_result_d = imm_sext;
                    rsp_zero_d   = (f_imm == '0);
                end else begin
                    rsp_result_d = result;
                    rsp_zero_d   = zero_flag;
                end
                state_d = (f_cls == CLS_CMP) ? ST_RESP : ST_WRITE;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (Rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        instr_ready_d = (state_d == ST_IDLE);
        rsp_valid_d   = (state_d == ST_RESP);
        we_d          = (state_d == ST_WRITE);

        // Addresses and operands are driven through READ and held into WRITE
        ra1_d     = '0;
        ra2_d     = '0;
        wa_d      = '0;
        opcode_d  = '0;
        mux_d     = 1'b0;
        data_in_d = '0;
        if ((state_d == ST_READ) || (state_d == ST_WRITE)) begin
            ra1_d     = f_rs1;
            ra2_d     = f_rs2;
            wa_d      = f_rd;
            opcode_d  = f_op;
            mux_d     = (f_cls != CLS_LOAD);
            data_in_d = (f_cls == CLS_LOAD) ? imm_sext : '0;
        end
    end

    // State and registered outputs; reset clears everything, aborting any
    // in-flight write or pending response
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            instr_q       <= '0;
            instr_ready_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            ra1_q         <= '0;
            ra2_q         <= '0;
            wa_q          <= '0;
            we_q          <= 1'b0;
            mux_q         <= 1'b0;
            opcode_q      <= '0;
            data_in_q     <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_ready_q <= instr_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_zero_q    <= rsp_zero_d;
            ra1_q         <= ra1_d;
            ra2_q         <= ra2_d;
            wa_q          <= wa_d;
            we_q          <= we_d;
            mux_q         <= mux_d;
            opcode_q      <= opcode_d;
            data_in_q     <= data_in_d;
        end
    end

    assign Instr_ready  = instr_ready_q;
    assign Rsp_valid    = rsp_valid_q;
    assign Rsp_result   = rsp_result_q;
    assign Rsp_zero     = rsp_zero_q;
    assign Read_Addr_1  = ra1_q;
    assign Read_Addr_2  = ra2_q;
    assign Write_Addr   = wa_q;
    assign Write_Enable = we_q;
    assign Mux_cntrl    = mux_q;
    assign opcode       = opcode_q;
    assign Data_in      = data_in_q;

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Multi-cycle control sequencer that drives the register-file/ALU datapath (`p7`) from a stream of 32-bit instruction words.
- It is the initiator for that datapath. It accepts one instruction on a valid/ready handshake, then drives read/write addresses, mux select, ALU opcode and immediate data.
- It captures the datapath's `result` and `zero_flag` and returns them on a valid/ready response channel.
- Its datapath-side outputs connect by name to the datapath inputs.

Parameters:
- DATA_W, 32, datapath word width (instruction format below is fixed for 32).
- ADDR_W, 5, register address width.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Instr_in  in  32  instruction word
- Instr_valid  in  1  instruction offered
- Instr_ready  out  1  sequencer can accept; high only in IDLE
- Rsp_valid  out  1  response available
- Rsp_ready  in  1  response consumer ready
- Rsp_result  out  DATA_W  captured result
- Rsp_zero  out  1  captured zero flag
- Read_Addr_1  out  ADDR_W  datapath read port 1 address
- Read_Addr_2  out  ADDR_W  datapath read port 2 address
- Write_Addr  out  ADDR_W  datapath write address
- Write_Enable  out  1  datapath write strobe
- Mux_cntrl  out  1  0 = write Data_in, 1 = write ALU result
- opcode  out  2  ALU op: 00 add, 10 sub, 01 OR, 11 AND (passed through unchanged)
- Data_in  out  DATA_W  immediate to datapath
- result  in  DATA_W  datapath ALU output
- zero_flag  in  1  datapath zero flag

Behaviour:
- Instruction fields:
  - [31:30] class: 00 LOAD, 01 ALU, 10 CMP, 11 NOP.
  - [29:28] alu_op, [27:23] rd, [22:18] rs1, [17:13] rs2, [15:0] imm (LOAD only).
- Reset values (all outputs registered):
  - All outputs 0, except Instr_ready, which goes to 1 on the first clock after Reset deasserts.
  - State is IDLE.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - Instr_ready=1.
  - On Instr_valid & Instr_ready, latch the instruction.
  - Next state: NOP -> RESP; all other classes -> READ.
- READ (one cycle):
  - Drive Read_Addr_1=rs1, Read_Addr_2=rs2, opcode=alu_op, Write_Addr=rd, Write_Enable=0.
  - Mux_cntrl = 1 for ALU/CMP; 0 for LOAD.
  - Data_in = sign-extended imm for LOAD; 0 otherwise.
  - At the end of the cycle, capture Rsp_result/Rsp_zero:
    - ALU/CMP: from result/zero_flag.
    - LOAD: sext(imm) and (imm==0).
  - Next state: CMP -> RESP; LOAD/ALU -> WRITE.
- WRITE (one cycle):
  - Write_Enable=1; all address, opcode, Mux_cntrl and Data_in outputs held from READ.
  - Write_Enable must be high for exactly one cycle per instruction. This prevents a second write of the post-update result when rd equals rs1 or rs2.
  - Next state: RESP.
- RESP:
  - Rsp_valid=1; Rsp_result/Rsp_zero stable.
  - Stay until Rsp_ready; on Rsp_valid & Rsp_ready go to IDLE.
  - Instr_ready is 0 here, so no overlap of instructions.
- Latency, counted from the accept edge to the first cycle Rsp_valid is high: LOAD/ALU 3 cycles, CMP 2, NOP 1.
- Throughput: with Rsp_ready tied high, LOAD/ALU can be accepted at most once every 4 cycles.
- NOP: Rsp_result=0, Rsp_zero=1; no datapath activity.
- Reset mid-operation: Write_Enable and Rsp_valid drop immediately (asynchronously); the in-flight instruction and pending response are discarded.
- Instr_in is ignored outside IDLE; Rsp_ready is ignored outside RESP.

Decomposition:
- Shared package contents:
  - Class codes: CLS_LOAD, CLS_ALU, CLS_CMP, CLS_NOP.
  - ALU op constants: OP_ADD=00, OP_SUB=10, OP_OR=01, OP_AND=11.
  - Field bit positions.
  - State enum: IDLE, READ, WRITE, RESP.
- No sub-module; field extraction is a few continuous assigns.
- The bench instantiates dp_sequencer together with p7 to close the loop.

Test Plan:
- LOAD r3 imm 0x0005, then LOAD r4 imm 0xFFFE -> responses 0x00000005/zero 0 and 0xFFFFFFFE/zero 0; Write_Enable high exactly 1 cycle each, with Mux_cntrl=0 during it.
- ALU ADD rd=5 rs1=3 rs2=4 -> Rsp_result 0x00000003, Rsp_zero 0; Rsp_valid 3 cycles after accept; a following CMP OR r5,r5 returns 0x00000003.
- CMP SUB rs1=3 rs2=3 -> Rsp_result 0, Rsp_zero 1; Write_Enable never asserted; Rsp_valid 2 cycles after accept.
- ALU OR rd=3 rs1=3 rs2=4 -> 0xFFFFFFFF; a following CMP AND r3,r3 returns 0xFFFFFFFF (confirms a single write with no re-write).
- Hold Rsp_ready low 5 cycles in RESP with Instr_valid high -> Rsp_valid and its data held, Instr_ready 0, nothing accepted until the handshake; NOP then returns 0/zero 1 one cycle after accept.
- Assert Reset during the WRITE cycle -> Write_Enable 0 immediately, no Rsp_valid; after release, Instr_ready 1 and the next LOAD completes normally.
